ex_issue_ctrl: RTL and testbench
================================

Name: ex_issue_ctrl

Overview:
- Sequences the EX stage for the four-lane PE datapath.
- Accepts one instruction at a time from decode and starts the selected PE lanes.
- For multi-cycle ops, waits until every masked lane reports ready; until then it drives bubbles (sclr) into the EX/WB pipeline register.
- Asserts pipe_e in exactly the cycle in which all lane results are valid at the register's inputs.

Parameters:
- NumLanes, 4, number of PE lanes; also the width of the mask, start and ready vectors.
- TimeoutCycles, 200, maximum WAIT duration before an op is abandoned; legal range 2..255.
- CntWidth, 16, width of the saturating stall counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- issue_valid  input  1  decode presents an instruction.
- issue_mask  input  NumLanes  lanes used by the instruction (des_mask).
- issue_multi  input  1  1 = multi-cycle op (PE handshake); 0 = single-cycle op.
- lane_ready  input  NumLanes  per-lane result-valid from the PEs.
- flush  input  1  pipeline flush.
- issue_ready  output  1  controller can accept an instruction this cycle.
- pe_start  output  NumLanes  one-cycle start pulse per masked lane.
- pe_abort  output  1  one-cycle pulse that cancels in-flight PE work.
- ex_sclr  output  1  drives sclr of the EX/WB pipeline register.
- ex_pipe  output  1  drives pipe_e of the EX/WB pipeline register.
- busy  output  1  controller is in WAIT.
- timeout_err  output  1  sticky: a WAIT exceeded TimeoutCycles.
- stall_cnt  output  CntWidth  saturating count of WAIT cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset state: state=IDLE, pending=0, wait_cnt=0, timeout_err=0, stall_cnt=0.
- Outputs while rstn=0: issue_ready=0, pe_start=0, pe_abort=0, ex_sclr=1, ex_pipe=0, busy=0.
- Output timing: ex_sclr, ex_pipe, issue_ready and pe_start are combinational from state plus inputs, so they line up with PE results in the capture cycle. All registers update on the posedge.
- States: IDLE, WAIT.
- IDLE, outputs: issue_ready=1, busy=0.
- IDLE, no accepted issue: when issue_valid=0, or flush=1, the cycle is a bubble: ex_sclr=1, ex_pipe=0.
- IDLE, single-cycle accept (issue_valid=1 and issue_multi=0): ex_pipe=1, ex_sclr=0, stay in IDLE. Zero added latency.
- IDLE, multi-cycle accept with empty mask (issue_valid=1, issue_multi=1, issue_mask=0): treated exactly as single-cycle.
- IDLE, multi-cycle accept (issue_valid=1, issue_multi=1, issue_mask!=0):
  - pe_start=issue_mask for one cycle; ex_sclr=1, ex_pipe=0.
  - Next state: pending<=issue_mask, wait_cnt<=0, state<=WAIT.
- WAIT, every cycle: issue_ready=0, busy=1; stall_cnt increments and saturates at all-ones.
- WAIT, completion: done = ((pending & ~lane_ready)==0).
  - If done: ex_pipe=1, ex_sclr=0, state<=IDLE, pending<=0.
  - If not done: pending<=pending & ~lane_ready, ex_sclr=1, ex_pipe=0.
- Ready handling: lane_ready bits on unmasked lanes are ignored. A lane that pulses ready early stays cleared in pending; the lane itself must hold its result valid until capture.
- Timeout: wait_cnt increments each WAIT cycle. If wait_cnt==TimeoutCycles-1 and not done:
  - timeout_err<=1 (sticky until reset);
  - pe_abort=1, ex_sclr=1, state<=IDLE, pending<=0.
- Flush, any state: flush=1 has priority over everything else.
  - ex_sclr=1, ex_pipe=0, pe_start=0.
  - pe_abort=1 if state==WAIT.
  - state<=IDLE, pending<=0, wait_cnt<=0.
  - issue_ready=1 in IDLE, but no instruction is accepted in a flush cycle.
- Simultaneous done and timeout in the same cycle: done wins; the result is captured, no error is raised.
- Reset mid-WAIT: the PE lanes are reset by the same rstn; no abort pulse is issued.

Decomposition:
- Shared package ex_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_WAIT=1'b1;
  - NumLanes default 4, used by both this block and the EX/WB pipeline register;
  - TimeoutCycles default.
- Sub-module ex_sat_counter: a parameterised saturating up-counter with clear and enable, instantiated for stall_cnt.
- Everything else stays flat.

Test Plan:
- Single-cycle issue, mask=4'b1111, multi=0 -> same cycle ex_pipe=1, ex_sclr=0, issue_ready=1; stall_cnt stays 0.
- Multi-cycle issue, mask=4'b0101, lane0 ready at cycle 2, lane2 ready at cycle 5 -> pe_start=4'b0101 for one cycle; ex_sclr=1 in cycles 0..4; ex_pipe=1 only in cycle 5; stall_cnt=5.
- Multi-cycle issue, mask=4'b0011, lane_ready=4'b1100 held -> no completion; at wait cycle 199 timeout_err=1 and pe_abort pulses; next cycle IDLE with issue_ready=1.
- Flush in WAIT cycle 3 while lane_ready=mask -> ex_pipe=0, ex_sclr=1, pe_abort=1; next cycle IDLE; the concurrent issue_valid is not accepted.
- Multi-cycle issue with mask=0 -> behaves as single-cycle: ex_pipe=1 same cycle, pe_start=0, never enters WAIT.
- rstn deasserted asynchronously mid-WAIT -> immediately ex_sclr=1, issue_ready=0, busy=0; after release: IDLE, stall_cnt=0, timeout_err=0.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the EX stage.
//   - State encoding of the issue controller FSM.
//   - Default lane count, shared with the EX/WB pipeline register.
//   - Default WAIT timeout, in cycles.
package ex_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam int NUM_LANES      = 4;
  localparam int TIMEOUT_CYCLES = 200;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT
  } state_t;

endpackage

// File: rtl/ex_sat_counter.sv
// ex_sat_counter: saturating up-counter with synchronous clear and enable.
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear, has priority over en
//   en    - count up by one; holds at all-ones
//   count - current count value
module ex_sat_counter #(
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + One;
    end
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: EX-stage sequencer for the four-lane PE datapath.
// Accepts one instruction at a time, starts the masked PE lanes and, for
// multi-cycle ops, holds bubbles in the EX/WB register until every masked
// lane has reported ready. ex_pipe fires in the cycle all results are valid.
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   issue_valid    - decode presents an instruction
//   issue_mask     - lanes used by the instruction
//   issue_multi    - 1 = multi-cycle (PE handshake), 0 = single-cycle
//   lane_ready     - per-lane result-valid from the PEs
//   flush          - pipeline flush, highest priority
//   issue_ready    - instruction can be accepted this cycle
//   pe_start       - one-cycle start pulse per masked lane
//   pe_abort       - one-cycle cancel of in-flight PE work
//   ex_sclr        - sclr of the EX/WB pipeline register
//   ex_pipe        - pipe_e of the EX/WB pipeline register
//   busy           - controller is in WAIT
//   timeout_err    - sticky WAIT timeout flag
//   stall_cnt      - saturating count of WAIT cycles
module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int NumLanes      = NUM_LANES,
  parameter int TimeoutCycles = TIMEOUT_CYCLES,
  parameter int CntWidth      = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                issue_valid,
  input  logic [NumLanes-1:0] issue_mask,
  input  logic                issue_multi,
  input  logic [NumLanes-1:0] lane_ready,
  input  logic                flush,
  output logic                issue_ready,
  output logic [NumLanes-1:0] pe_start,
  output logic                pe_abort,
  output logic                ex_sclr,
  output logic                ex_pipe,
  output logic                busy,
  output logic                timeout_err,
  output logic [CntWidth-1:0] stall_cnt
);

  // TimeoutCycles is at most 255, so eight bits always hold wait_cnt.
  localparam int         WaitW   = 8;
  localparam logic [7:0] WaitLast = 8'(TimeoutCycles - 1);

  state_t              state, state_nxt;
  logic [NumLanes-1:0] pending, pending_nxt;
  logic [WaitW-1:0]    wait_cnt, wait_cnt_nxt;
  logic                err_set;
  logic                done;

  assign done = ((pending & ~lane_ready) == '0);

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      pending     <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) timeout_err <= 1'b1;
    end
  end

  // Next state and combinational outputs. Outputs are gated by rstn so the
  // EX/WB register sees bubbles while reset is asserted.
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    wait_cnt_nxt = wait_cnt;
    err_set      = 1'b0;
    issue_ready  = 1'b0;
    pe_start     = '0;
    pe_abort     = 1'b0;
    ex_sclr      = 1'b1;
    ex_pipe      = 1'b0;
    busy         = 1'b0;

    if (rstn) begin
      unique case (state)
        S_IDLE: begin
          issue_ready = 1'b1;
          if (flush) begin
            pending_nxt  = '0;
            wait_cnt_nxt = '0;
          end else if (issue_valid) begin
            // An empty-mask multi-cycle op has nothing to wait on.
            if (!issue_multi || (issue_mask == '0)) begin
              ex_pipe = 1'b1;
              ex_sclr = 1'b0;
            end else begin
              pe_start     = issue_mask;
              state_nxt    = S_WAIT;
              pending_nxt  = issue_mask;
              wait_cnt_nxt = '0;
            end
          end
        end

        S_WAIT: begin
          busy         = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (flush) begin
            pe_abort     = 1'b1;
            state_nxt    = S_IDLE;
            pending_nxt  = '0;
            wait_cnt_nxt = '0;
          end else if (done) begin
            // Checked before the timeout so a last-cycle completion is kept.
            ex_pipe     = 1'b1;
            ex_sclr     = 1'b0;
            state_nxt   = S_IDLE;
            pending_nxt = '0;
          end else if (wait_cnt == WaitLast) begin
            err_set     = 1'b1;
            pe_abort    = 1'b1;
            state_nxt   = S_IDLE;
            pending_nxt = '0;
          end else begin
            // Early ready pulses stay cleared; the lane holds its result.
            pending_nxt = pending & ~lane_ready;
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  ex_sat_counter #(
    .Width (CntWidth)
  ) u_stall_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (1'b0),
    .en    (state == S_WAIT),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb_ex_issue_ctrl: directed scoreboard bench for ex_issue_ctrl.
// Stimulus drives one cycle at a time and queues the hand-computed outputs
// for that cycle; a monitor pops and compares on the falling edge.
module tb_ex_issue_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_mask = '0;
  logic        issue_multi = 1'b0;
  logic [3:0]  lane_ready = '0;
  logic        flush = 1'b0;
  logic        issue_ready;
  logic [3:0]  pe_start;
  logic        pe_abort;
  logic        ex_sclr;
  logic        ex_pipe;
  logic        busy;
  logic        timeout_err;
  logic [15:0] stall_cnt;

  ex_issue_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_valid (issue_valid),
    .issue_mask  (issue_mask),
    .issue_multi (issue_multi),
    .lane_ready  (lane_ready),
    .flush       (flush),
    .issue_ready (issue_ready),
    .pe_start    (pe_start),
    .pe_abort    (pe_abort),
    .ex_sclr     (ex_sclr),
    .ex_pipe     (ex_pipe),
    .busy        (busy),
    .timeout_err (timeout_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ir;
    logic [3:0] st;
    logic       ab;
    logic       sclr;
    logic       pipe;
    logic       bz;
    logic       terr;
    int         sc;   // negative: stall_cnt not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Apply one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input string nm, input logic rn, input logic v,
                      input logic [3:0] m, input logic mu, input logic [3:0] r,
                      input logic f, input logic ir, input logic [3:0] st,
                      input logic ab, input logic sclr, input logic pipe,
                      input logic bz, input logic terr, input int sc);
    exp_t e;
    @(posedge clk);
    #1;
    rstn        = rn;
    issue_valid = v;
    issue_mask  = m;
    issue_multi = mu;
    lane_ready  = r;
    flush       = f;
    e.name = nm; e.ir = ir; e.st = st; e.ab = ab; e.sclr = sclr;
    e.pipe = pipe; e.bz = bz; e.terr = terr; e.sc = sc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [9:0] act, want;
      e    = sb.pop_front();
      act  = {issue_ready, pe_start, pe_abort, ex_sclr, ex_pipe, busy, timeout_err};
      want = {e.ir, e.st, e.ab, e.sclr, e.pipe, e.bz, e.terr};
      n_vec++;
      if ((act !== want) || ((e.sc >= 0) && (stall_cnt !== 16'(e.sc)))) begin
        n_err++;
        $display("FAIL %s: got {rdy,start,abort,sclr,pipe,busy,err}=%b cnt=%0d, want %b cnt=%0d",
                 e.name, act, stall_cnt, want, e.sc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   name        rn v  mask  mu ready f   ir st    ab sc pp bz te cnt
    // Reset: outputs gated even with a valid multi-cycle issue present.
    step("rst_hold",  0, 1, 4'hf, 1, 4'h0, 0,  0, 4'h0, 0, 1, 0, 0, 0, 0);
    step("idle",      1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 0);

    // Single-cycle issue: capture in the same cycle.
    step("single",    1, 1, 4'hf, 0, 4'h0, 0,  1, 4'h0, 0, 0, 1, 0, 0, 0);
    step("single_n",  1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 0);

    // Multi-cycle mask 0101: lane0 early at cycle 2, unmasked noise, lane2 at 5.
    step("m_issue",   1, 1, 4'h5, 1, 4'h0, 0,  1, 4'h5, 0, 1, 0, 0, 0, 0);
    step("m_w1",      1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 0, 0);
    step("m_w2",      1, 0, 4'h0, 0, 4'h1, 0,  0, 4'h0, 0, 1, 0, 1, 0, 1);
    step("m_w3",      1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 0, 2);
    step("m_w4_unm",  1, 0, 4'h0, 0, 4'ha, 0,  0, 4'h0, 0, 1, 0, 1, 0, 3);
    step("m_done",    1, 0, 4'h0, 0, 4'h4, 0,  0, 4'h0, 0, 0, 1, 1, 0, 4);
    step("m_idle",    1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 5);

    // Multi-cycle with empty mask behaves as single-cycle.
    step("m0_issue",  1, 1, 4'h0, 1, 4'h0, 0,  1, 4'h0, 0, 0, 1, 0, 0, 5);
    step("m0_after",  1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 5);

    // Flush in IDLE blocks acceptance of both op kinds.
    step("fi_single", 1, 1, 4'hf, 0, 4'h0, 1,  1, 4'h0, 0, 1, 0, 0, 0, 5);
    step("fi_multi",  1, 1, 4'h3, 1, 4'h0, 1,  1, 4'h0, 0, 1, 0, 0, 0, 5);
    step("fi_after",  1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 5);

    // Timeout: mask 0011 with only unmasked lanes ready.
    step("to_issue",  1, 1, 4'h3, 1, 4'hc, 0,  1, 4'h3, 0, 1, 0, 0, 0, 5);
    for (int k = 0; k < 200; k++)
      step("to_wait",   1, 0, 4'h0, 0, 4'hc, 0,  0, 4'h0, (k == 199), 1, 0, 1, 0, 5 + k);
    step("to_idle",   1, 0, 4'h0, 0, 4'hc, 0,  1, 4'h0, 0, 1, 0, 0, 1, 205);

    // Flush in WAIT cycle 3 while all lanes are ready and decode issues.
    step("fw_issue",  1, 1, 4'h3, 1, 4'h0, 0,  1, 4'h3, 0, 1, 0, 0, 1, 205);
    step("fw_w1",     1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 1, 205);
    step("fw_w2",     1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 1, 206);
    step("fw_flush",  1, 1, 4'hf, 0, 4'h3, 1,  0, 4'h0, 1, 1, 0, 1, 1, 207);
    step("fw_idle",   1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 1, -1);
    step("fw_single", 1, 1, 4'h1, 0, 4'h0, 0,  1, 4'h0, 0, 0, 1, 0, 1, -1);

    // Asynchronous reset mid-WAIT: no abort, counters cleared immediately.
    step("ar_issue",  1, 1, 4'hf, 1, 4'h0, 0,  1, 4'hf, 0, 1, 0, 0, 1, -1);
    step("ar_wait",   1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 1, -1);
    step("ar_assert", 0, 1, 4'hf, 0, 4'hf, 0,  0, 4'h0, 0, 1, 0, 0, 0, 0);
    step("ar_release",1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 0);

    // Completion in the timeout cycle wins: capture, no error.
    step("dt_issue",  1, 1, 4'h1, 1, 4'h0, 0,  1, 4'h1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 199; k++)
      step("dt_wait",   1, 0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 0, 1, 0, 1, 0, k);
    step("dt_done",   1, 0, 4'h0, 0, 4'h1, 0,  0, 4'h0, 0, 0, 1, 1, 0, 199);
    step("dt_idle",   1, 0, 4'h0, 0, 4'h0, 0,  1, 4'h0, 0, 1, 0, 0, 0, 200);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
